// File: rtl/pulse_train_pkg.sv
// Shared definitions for the count/direction pulse-train generator.
//   - FSM state encoding
//   - default widths for pulse count and period fields
//   - command record layout at the default widths
package pulse_train_pkg;

    localparam int unsigned COUNT_WIDTH_DEF  = 32'd16;
    localparam int unsigned PERIOD_WIDTH_DEF = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } pt_state_e;

    // Command record at the default widths; the generator builds the same
    // layout from its own width parameters.
    typedef struct packed {
        logic [COUNT_WIDTH_DEF-1:0]  count;
        logic                        dir;
        logic [PERIOD_WIDTH_DEF-1:0] period;
    } pt_cmd_t;

endpackage

// File: rtl/pulse_period_timer.sv
// Loadable period down-counter for the pulse-train generator.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            restart with a new period (0 is treated as 1)
//   en              advance one cycle; reloads itself at the end of a period
//   period          period in cycles, sampled on load
//   period_end      current cycle is the last cycle of a period (the tick)
//   period_end_nx   period_end value the next cycle will have, given load/en
module pulse_period_timer
    import pulse_train_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_end,
    output logic                    period_end_nx
);

    localparam logic [PERIOD_WIDTH-1:0] PER_ZERO = {PERIOD_WIDTH{1'b0}};
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = PERIOD_WIDTH'(1'b1);

    logic [PERIOD_WIDTH-1:0] cnt_r;     // cycles left in this period after the current one
    logic [PERIOD_WIDTH-1:0] reload_r;  // effective period latched on load
    logic [PERIOD_WIDTH-1:0] eff_s;     // max(period, 1)

    // Clamp a zero period to one so P=0 behaves as a pulse every cycle.
    always_comb begin
        if (period == PER_ZERO) begin
            eff_s = PER_ONE;
        end else begin
            eff_s = period;
        end
    end

    // Counter and reload value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= PER_ZERO;
            reload_r <= PER_ONE;
        end else if (load) begin
            cnt_r    <= eff_s - PER_ONE;
            reload_r <= eff_s;
        end else if (en) begin
            if (cnt_r == PER_ZERO) begin
                cnt_r <= reload_r - PER_ONE;
            end else begin
                cnt_r <= cnt_r - PER_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign period_end = (cnt_r == PER_ZERO);

    // Look-ahead of period_end so the owner can register done in time.
    always_comb begin
        period_end_nx = 1'b0;
        if (load) begin
            period_end_nx = (eff_s == PER_ONE);
        end else if (en) begin
            if (cnt_r == PER_ZERO) begin
                period_end_nx = (reload_r == PER_ONE);
            end else begin
                period_end_nx = (cnt_r == PER_ONE);
            end
        end else begin
            period_end_nx = (cnt_r == PER_ZERO);
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// Count/direction pulse-train generator. Emits N single-cycle pulses spaced
// P cycles apart with a direction level, driven by a valid/ready command
// interface with one pending slot.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready is combinational)
//   cmd_count/dir/period  pulse count, direction (0 up, 1 down), period
//   abort               drop active and pending commands
//   pulse               single-cycle count strobe
//   ud                  direction level, changes only in SETUP
//   busy                a command is in SETUP or RUN
//   done                last cycle of a completed command
//   remaining           pulses not yet emitted for the active command
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH  = COUNT_WIDTH_DEF,
    parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [COUNT_WIDTH-1:0]  cmd_count,
    input  logic                    cmd_dir,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                    abort,
    output logic                    pulse,
    output logic                    ud,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  remaining
);

    typedef struct packed {
        logic [COUNT_WIDTH-1:0]  count;
        logic                    dir;
        logic [PERIOD_WIDTH-1:0] period;
    } cmd_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1'b1);
    localparam cmd_t CMD_ZERO = '{count: {COUNT_WIDTH{1'b0}}, dir: 1'b0,
                                  period: {PERIOD_WIDTH{1'b0}}};

    pt_state_e              state_r, state_nx_s;
    cmd_t                   act_r, act_nx_s;
    cmd_t                   pend_r, pend_nx_s;
    logic                   pend_full_r, pend_full_nx_s;
    cmd_t                   in_cmd_s;
    // Pulses still to be emitted after the current cycle.
    logic [COUNT_WIDTH-1:0] left_r, left_nx_s;
    logic [COUNT_WIDTH-1:0] remaining_r, remaining_nx_s, remaining_dec_s;
    logic                   pulse_r, pulse_nx_s;
    logic                   done_r, done_nx_s;
    logic                   busy_r, busy_nx_s;
    logic                   ud_r, ud_nx_s;
    logic                   hs_s, finish_s;
    logic                   tmr_load_s, tmr_en_s;
    logic                   period_end_s, period_end_nx_s;

    pulse_period_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .load          (tmr_load_s),
        .en            (tmr_en_s),
        .period        (act_r.period),
        .period_end    (period_end_s),
        .period_end_nx (period_end_nx_s)
    );

    assign cmd_ready = !pend_full_r && !abort;

    // Handshake, incoming command record, and end-of-command detection.
    always_comb begin
        hs_s            = cmd_valid && cmd_ready;
        in_cmd_s.count  = cmd_count;
        in_cmd_s.dir    = cmd_dir;
        in_cmd_s.period = cmd_period;
        finish_s        = ((state_r == ST_SETUP) && (act_r.count == CNT_ZERO)) ||
                          ((state_r == ST_RUN) && period_end_s && (left_r == CNT_ZERO));
        if (pulse_r && (remaining_r != CNT_ZERO)) begin
            remaining_dec_s = remaining_r - CNT_ONE;
        end else begin
            remaining_dec_s = remaining_r;
        end
    end

    // Next state and next-cycle output values. Outputs are registered, so
    // they are derived from the next-state values computed here.
    always_comb begin
        state_nx_s     = state_r;
        act_nx_s       = act_r;
        pend_nx_s      = pend_r;
        pend_full_nx_s = pend_full_r;
        left_nx_s      = left_r;
        remaining_nx_s = remaining_r;
        ud_nx_s        = ud_r;
        pulse_nx_s     = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_en_s       = 1'b0;

        if (abort) begin
            state_nx_s     = ST_IDLE;
            pend_full_nx_s = 1'b0;
            left_nx_s      = CNT_ZERO;
            remaining_nx_s = CNT_ZERO;
        end else if (finish_s) begin
            // A queued command takes priority; otherwise a command accepted
            // in this cycle goes straight to SETUP.
            remaining_nx_s = remaining_dec_s;
            if (pend_full_r) begin
                state_nx_s     = ST_SETUP;
                act_nx_s       = pend_r;
                pend_full_nx_s = 1'b0;
                ud_nx_s        = pend_r.dir;
                remaining_nx_s = pend_r.count;
            end else if (hs_s) begin
                state_nx_s     = ST_SETUP;
                act_nx_s       = in_cmd_s;
                ud_nx_s        = in_cmd_s.dir;
                remaining_nx_s = in_cmd_s.count;
            end else begin
                state_nx_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        state_nx_s     = ST_SETUP;
                        act_nx_s       = in_cmd_s;
                        ud_nx_s        = in_cmd_s.dir;
                        remaining_nx_s = in_cmd_s.count;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // Count is non-zero here; first pulse lands in the first RUN cycle.
                    state_nx_s = ST_RUN;
                    tmr_load_s = 1'b1;
                    pulse_nx_s = 1'b1;
                    left_nx_s  = act_r.count - CNT_ONE;
                    if (hs_s) begin
                        pend_nx_s      = in_cmd_s;
                        pend_full_nx_s = 1'b1;
                    end else begin
                        pend_full_nx_s = pend_full_r;
                    end
                end
                ST_RUN: begin
                    tmr_en_s       = 1'b1;
                    remaining_nx_s = remaining_dec_s;
                    if (period_end_s) begin
                        pulse_nx_s = 1'b1;
                        left_nx_s  = left_r - CNT_ONE;
                    end else begin
                        left_nx_s = left_r;
                    end
                    if (hs_s) begin
                        pend_nx_s      = in_cmd_s;
                        pend_full_nx_s = 1'b1;
                    end else begin
                        pend_full_nx_s = pend_full_r;
                    end
                end
                default: begin
                    state_nx_s     = ST_IDLE;
                    remaining_nx_s = CNT_ZERO;
                end
            endcase
        end

        busy_nx_s = (state_nx_s != ST_IDLE);
        if (state_nx_s == ST_SETUP) begin
            done_nx_s = (act_nx_s.count == CNT_ZERO);
        end else if (state_nx_s == ST_RUN) begin
            done_nx_s = period_end_nx_s && (left_nx_s == CNT_ZERO);
        end else begin
            done_nx_s = 1'b0;
        end
    end

    // State, command slots and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            act_r       <= CMD_ZERO;
            pend_r      <= CMD_ZERO;
            pend_full_r <= 1'b0;
            left_r      <= CNT_ZERO;
            remaining_r <= CNT_ZERO;
            pulse_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            ud_r        <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            act_r       <= act_nx_s;
            pend_r      <= pend_nx_s;
            pend_full_r <= pend_full_nx_s;
            left_r      <= left_nx_s;
            remaining_r <= remaining_nx_s;
            pulse_r     <= pulse_nx_s;
            done_r      <= done_nx_s;
            busy_r      <= busy_nx_s;
            ud_r        <= ud_nx_s;
        end
    end

    // Abort must silence the strobe and completion flag in the abort cycle
    // itself, so the registered values are qualified by it.
    assign pulse     = pulse_r && !abort;
    assign done      = done_r && !abort;
    assign busy      = busy_r;
    assign ud        = ud_r;
    assign remaining = remaining_r;

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Generates a programmed number of single-cycle count pulses with a direction level, at a programmed period, for driving up/down pulse counters and step/direction motor interfaces in the car datapath. It is the transmitting end of the count/direction pulse interface: a same-clock counter sampling `pulse` as its count strobe and `ud` as its direction accumulates exactly the commanded count. Commands arrive over a valid/ready handshake with a one-deep pending slot, so back-to-back bursts run without idle gaps beyond one direction-setup cycle.

## Interface
- `COUNT_WIDTH`, 16: width of pulse count and `remaining`
- `PERIOD_WIDTH`, 16: width of period field
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command slot free; handshake when `cmd_valid && cmd_ready` at a rising edge
- `cmd_count`  in  COUNT_WIDTH  number of pulses, 0..2^COUNT_WIDTH-1
- `cmd_dir`  in  1  direction: 0 = up, 1 = down (same encoding as counter `ud`)
- `cmd_period`  in  PERIOD_WIDTH  cycles between pulse rising edges
- `abort`  in  1  drop active and pending commands
- `pulse`  out  1  single-cycle count strobe
- `ud`  out  1  direction level for the active command
- `busy`  out  1  a command is active (SETUP or RUN)
- `done`  out  1  single-cycle, marks the last cycle of each completed command
- `remaining`  out  COUNT_WIDTH  pulses not yet emitted for the active command

## Operation
- Storage: active registers (count, dir, period) plus one pending slot; `cmd_ready = !pending_full && !abort`.
- Accepted command goes to active if the FSM is IDLE or is finishing (`done` cycle) with no pending command; otherwise it goes to pending.
- FSM states:
  - IDLE: `busy=0`.
  - SETUP: one cycle, `busy=1`; `ud` takes the new direction and `remaining` loads N.
  - RUN: emit pulses.
- Transitions:
  - IDLE→SETUP on handshake.
  - SETUP→RUN if N>0.
  - SETUP→(IDLE or SETUP) if N=0: `done` is asserted in the SETUP cycle and no pulse is emitted.
  - RUN→SETUP at end of command if pending (pending moves to active); else RUN→IDLE.
- Period: effective P = max(`cmd_period`, 1). With P=1, `pulse` is high every RUN cycle.
- Pulses: in RUN, pulse k is emitted at cycle t0+k·P for k=0..N-1, where t0 is the first RUN cycle. The command occupies exactly N·P RUN cycles, and `done` is asserted in cycle t0+N·P-1.
- `remaining` decrements by 1 in the cycle after each pulse and reaches 0 in the cycle after the last pulse. It never wraps.
- `ud` changes only in SETUP and otherwise holds its last value, including through IDLE.
- Abort, synchronous, highest priority after `rst`:
  - `pulse` is 0 in the abort cycle.
  - Next cycle: IDLE, pending cleared, `remaining`=0, `ud` held.
  - No `done` is asserted for the aborted command.
  - `cmd_valid` in the abort cycle is not accepted.
- Reset values: `pulse`=0, `ud`=0, `busy`=0, `done`=0, `remaining`=0, pending empty, FSM IDLE. `cmd_ready`=1 in the first cycle after `rst` deasserts.
- Reset mid-burst: output stops at the next edge, with no partial `done`.

## Timing
- Handshake at edge of cycle A: A+1 is SETUP (`ud` valid, `busy`=1); A+2 carries the first `pulse` (latency 2).
- `ud` is stable at least one cycle before the first pulse of each command and through its last pulse.
- Back-to-back: command 1 ends (`done`) at cycle E; SETUP of command 2 is at E+1; its first pulse is at E+2.
- A handshake in the `done` cycle with nothing pending follows the same rule as the back-to-back case: SETUP at E+1.
- All outputs are registered except `cmd_ready`.

## Structure
- Package `pulse_train_pkg`:
  - FSM state enum (IDLE, SETUP, RUN)
  - default width constants
  - command struct {count, dir, period}
- Sub-module `pulse_period_timer`: loadable down-counter of width PERIOD_WIDTH that emits a tick every P cycles while enabled and restarts on load.
- Top level holds the FSM, the active/pending command slots and the `remaining` counter.

## Test plan
- N=3, dir=0, P=4 accepted at cycle 10 → SETUP at 11; pulses at 12, 16, 20; `done` at 23; `remaining` 3,2,1,0. A same-clock counter shows +3.
- N=0, dir=1 → SETUP has `done`=1, no pulse, `ud`=1, `busy` drops next cycle.
- Command A (N=2, P=1, up) followed immediately by command B (N=2, P=3, down) → `cmd_ready` low while B is pending. A's pulses at t, t+1 and `done` at t+1; SETUP at t+2 with `ud`=1; B's pulses at t+3, t+6. Counter nets 0.
- P=0 with N=5 → behaves as P=1: five consecutive pulse cycles.
- Abort after the 2nd of N=10 pulses, with a command pending → no further pulse, no `done`, pending dropped, `cmd_ready`=1 after the abort cycle, `remaining`=0.
- `rst` asserted mid-burst → next cycle all outputs at reset values. N=65535 runs to completion and `remaining` never wraps.
